riscv_multicycle_control: RTL and testbench

- Moore-style control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback.
- Generates the 2-bit result_src select consumed by the writeback mux: 00 = ALU result, 01 = memory data, 10 = PC+4 link for JAL.
- Also drives all datapath enables and selects, and the ALU operation.

---
 rtl/riscv_multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_riscv_multicycle_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, select and the ALU operation.
module riscv_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               pc_src,
  output logic               adr_src,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t r_state;
  state_t w_next;
  ctl_t   r_ctl;
  logic [2:0] w_alu_dec;
  logic       w_legal;

  // State-only outputs; computed for the state being entered so they register with it.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER: c.alu_src_a = 2'b10;
      S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_JAL: begin
        c.result_src = 2'b10;
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
        c.pc_src     = 1'b1;
      end
      S_BEQ: begin c.alu_src_a = 2'b10; c.alu_op = ALU_SUB; c.pc_src = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_legal = (opcode == OP_LOAD) || (opcode == OP_STORE) || (opcode == OP_R) ||
              (opcode == OP_I) || (opcode == OP_JAL) || (opcode == OP_BEQ);
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECUTER;
          OP_I:              w_next = S_EXECUTEI;
          OP_JAL:            w_next = S_JAL;
          OP_BEQ:            w_next = S_BEQ;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ctl   <= ctl_of(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_of(w_next);
    end
  end

  // Only R-type may subtract on funct3=000; addi always adds.
  always_comb begin
    case (funct3)
      3'b000:  w_alu_dec = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign alu_control = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) ?
                       w_alu_dec : r_ctl.alu_op;
  assign pc_write    = r_ctl.pc_write | ((r_state == S_BEQ) & zero);
  assign illegal     = (r_state == S_DECODE) & ~w_legal;
  assign pc_src      = r_ctl.pc_src;
  assign adr_src     = r_ctl.adr_src;
  assign ir_write    = r_ctl.ir_write;
  assign mem_write   = r_ctl.mem_write;
  assign reg_write   = r_ctl.reg_write;
  assign result_src  = r_ctl.result_src;
  assign alu_src_a   = r_ctl.alu_src_a;
  assign alu_src_b   = r_ctl.alu_src_b;
  assign state       = STATE_W'(r_state);

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for riscv_multicycle_control: per-opcode state-path model checked
// every cycle, plus hand-computed expectations for each instruction class.
module tb_riscv_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, pc_src, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic [3:0] state;

  riscv_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .pc_src(pc_src), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] ECAL = 7'b1110011;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each instruction class is a fixed walk through state codes.
  function automatic int path_len(input logic [6:0] op);
    case (op)
      LW:               return 5;
      SW, RT, IT:       return 4;
      JAL, BEQ:         return 3;
      default:          return 2;
    endcase
  endfunction

  function automatic int path_state(input logic [6:0] op, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    case (op)
      LW:      return (idx == 2) ? 2 : (idx == 3) ? 3 : 4;
      SW:      return (idx == 2) ? 2 : 5;
      RT:      return (idx == 2) ? 6 : 8;
      IT:      return (idx == 2) ? 7 : 8;
      JAL:     return 9;
      BEQ:     return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7);
    if (f3 == 3'b000) return (op == RT && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  // {pc_write,pc_src,adr_src,ir_write,mem_write,reg_write,result_src,a,b,alu,imm,illegal}
  function automatic logic [17:0] exp_vec(input int st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pw, ps, adr, irw, mw, rw, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    pw = 0; ps = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    rs = 0; a = 0; b = 0; alu = 0;
    imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin irw = 1; pw = 1; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01;
                ill = !(op == LW || op == SW || op == RT || op == IT || op == JAL || op == BEQ); end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; alu = alu_of(op, f3, f7); end
      7:  begin a = 2'b10; b = 2'b01; alu = alu_of(op, f3, f7); end
      8:  rw = 1;
      9:  begin rs = 2'b10; rw = 1; pw = 1; ps = 1; end
      10: begin a = 2'b10; alu = 3'b001; ps = 1; pw = z; end
      default: ;
    endcase
    return {pw, ps, adr, irw, mw, rw, rs, a, b, alu, imm, ill};
  endfunction

  int m_idx = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_idx <= 0;
    else     m_idx <= (m_idx + 1 >= path_len(opcode)) ? 0 : m_idx + 1;
  end

  int          c_exp_st;
  logic [17:0] c_dut_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      c_exp_st  = path_state(opcode, m_idx);
      c_dut_vec = {pc_write, pc_src, adr_src, ir_write, mem_write, reg_write, result_src,
                   alu_src_a, alu_src_b, alu_control, imm_src, illegal};
      chk("model_state", 32'(state), 32'(c_exp_st));
      chk("model_outputs", 32'(c_dut_vec),
          32'(exp_vec(c_exp_st, opcode, funct3, funct7b5, zero)));
    end
  end

  logic [31:0] seq;
  logic [1:0]  cap_rs  [8];
  logic [2:0]  cap_alu [8];
  logic [1:0]  cap_imm [8];
  logic        cap_rw  [8];
  logic        cap_pw  [8];
  logic        cap_ps  [8];
  logic        cap_mw  [8];
  logic        cap_adr [8];
  logic        cap_ill [8];

  // Called at a negedge while in FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int n);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    seq = 32'd0;
    for (int i = 0; i < n; i++) begin
      #3;
      seq = (seq << 4) | 32'(state);
      cap_rs[i] = result_src; cap_alu[i] = alu_control; cap_imm[i] = imm_src;
      cap_rw[i] = reg_write;  cap_pw[i] = pc_write;     cap_ps[i] = pc_src;
      cap_mw[i] = mem_write;  cap_adr[i] = adr_src;     cap_ill[i] = illegal;
      @(negedge clk);
    end
    chk({name, "_return_fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int cnt;
  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fetch_ctl", {27'd0, ir_write, pc_write, alu_src_b, mem_write | reg_write},
        {27'd0, 1'b1, 1'b1, 2'b10, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    run_instr("lw", LW, 3'b010, 1'b0, 1'b0, 5);
    chk("lw_seq", seq, 32'h01234);
    chk("lw_wb", {30'd0, cap_rs[4]}, 32'd1);
    chk("lw_wb_regwrite", 32'(cap_rw[4]), 32'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) cnt += int'(cap_adr[i]);
    chk("lw_adr_src_once", 32'(cnt), 32'd1);
    chk("lw_adr_src_memread", 32'(cap_adr[3]), 32'd1);

    run_instr("sub", RT, 3'b000, 1'b1, 1'b0, 4);
    chk("sub_seq", seq, 32'h0168);
    chk("sub_alu", 32'(cap_alu[2]), 32'd1);
    chk("sub_wb_src", 32'(cap_rs[3]), 32'd0);
    chk("sub_wb_regwrite", 32'(cap_rw[3]), 32'd1);

    run_instr("addi", IT, 3'b000, 1'b1, 1'b0, 4);
    chk("addi_seq", seq, 32'h0178);
    chk("addi_alu", 32'(cap_alu[2]), 32'd0);

    run_instr("slt", RT, 3'b010, 1'b0, 1'b0, 4);
    chk("slt_alu", 32'(cap_alu[2]), 32'd5);
    run_instr("or", RT, 3'b110, 1'b0, 1'b0, 4);
    chk("or_alu", 32'(cap_alu[2]), 32'd3);
    run_instr("andi", IT, 3'b111, 1'b0, 1'b0, 4);
    chk("andi_alu", 32'(cap_alu[2]), 32'd2);

    run_instr("jal", JAL, 3'b000, 1'b0, 1'b0, 3);
    chk("jal_seq", seq, 32'h019);
    chk("jal_ctl", {28'd0, cap_rs[2], cap_rw[2], cap_pw[2]}, {28'd0, 2'b10, 1'b1, 1'b1});
    chk("jal_pc_src", 32'(cap_ps[2]), 32'd1);
    chk("jal_imm", {26'd0, cap_imm[0], cap_imm[1], cap_imm[2]}, {26'd0, 6'b111111});

    run_instr("beq_t", BEQ, 3'b000, 1'b0, 1'b1, 3);
    chk("beq_t_seq", seq, 32'h01A);
    chk("beq_t_pcw", 32'(cap_pw[2]), 32'd1);
    run_instr("beq_nt", BEQ, 3'b000, 1'b0, 1'b0, 3);
    chk("beq_nt_pcw", 32'(cap_pw[2]), 32'd0);

    run_instr("sw", SW, 3'b010, 1'b0, 1'b0, 4);
    chk("sw_seq", seq, 32'h0125);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += int'(cap_mw[i]);
    chk("sw_memwrite_once", 32'(cnt), 32'd1);
    chk("sw_memwrite_state5", 32'(cap_mw[3]), 32'd1);

    run_instr("ecall", ECAL, 3'b000, 1'b0, 1'b0, 2);
    chk("ecall_seq", seq, 32'h01);
    chk("ecall_illegal", {30'd0, cap_ill[0], cap_ill[1]}, 32'b01);

    opcode = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_memread", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_ctl",
        {26'd0, ir_write, pc_write, alu_src_b, mem_write, reg_write},
        {26'd0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    run_instr("lw_after_rst", LW, 3'b010, 1'b0, 1'b0, 5);
    chk("lw_after_rst_seq", seq, 32'h01234);

    chk_en = 1'b0;
    #10;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
